// File: rtl/hdc_pkg.sv
// Shared HDC front-end definitions: default window geometry, sample types and
// the window buffer's control-state encoding.
package hdc_pkg;

   localparam int unsigned SAMPLE_SIZE = 16;
   localparam int unsigned WINDOW_SIZE = 256;
   localparam int unsigned WINDOW_STEP = 128;

   typedef logic signed [SAMPLE_SIZE-1:0] sample_t;
   typedef sample_t window_t [WINDOW_SIZE];

   // Control view derived from primed/busy/boundary; not a separate state register.
   typedef enum logic [1:0] {
      ST_FILL,
      ST_STEP,
      ST_STEP_BUSY,
      ST_STALL
   } ctrl_state_e;

endpackage

// File: rtl/window_buffer.sv
// Sliding-window collector for one EEG channel: shifts accepted samples in,
// freezes a window snapshot every WINDOW_STEP samples and hands it to the extractor.
module window_buffer #(
   parameter int unsigned WINDOW_SIZE = hdc_pkg::WINDOW_SIZE,
   parameter int unsigned WINDOW_STEP = hdc_pkg::WINDOW_STEP,
   parameter int unsigned SAMPLE_SIZE = hdc_pkg::SAMPLE_SIZE,
   parameter int unsigned COUNT_W     = 16
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   in_valid,
   input  logic [SAMPLE_SIZE-1:0]                 in_sample,
   output logic                                   in_ready,
   output logic                                   win_en,
   output logic [WINDOW_SIZE-1:0][SAMPLE_SIZE-1:0] samples,
   input  logic                                   ext_done,
   output logic                                   busy,
   output logic [COUNT_W-1:0]                     win_count
);

   localparam int unsigned CNT_W = $clog2(WINDOW_SIZE) + 1;
   localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(WINDOW_SIZE - 1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WINDOW_STEP - 1);

   logic [WINDOW_SIZE-1:0][SAMPLE_SIZE-1:0] sh_q, sh_d;
   logic [WINDOW_SIZE-1:0][SAMPLE_SIZE-1:0] samples_q, samples_d;
   logic [CNT_W-1:0]                        cnt_q, cnt_d;
   logic                                    primed_q, primed_d;
   logic                                    busy_q, busy_d;
   logic                                    win_en_q, win_en_d;
   logic [COUNT_W-1:0]                      win_count_q, win_count_d;

   logic                  boundary;
   logic                  accept;
   hdc_pkg::ctrl_state_e  state;

   // Next accept completes a window when cnt reaches need-1.
   assign boundary = (cnt_q == (primed_q ? LAST_STEP : LAST_FILL));

   always_comb begin
      state = hdc_pkg::ST_FILL;
      if (primed_q) begin
         if (!busy_q)                     state = hdc_pkg::ST_STEP;
         else if (boundary && !ext_done)  state = hdc_pkg::ST_STALL;
         else                             state = hdc_pkg::ST_STEP_BUSY;
      end
   end

   // Only the window-completing sample is held off while the extractor runs.
   assign in_ready = !rst && (state != hdc_pkg::ST_STALL);
   assign accept   = in_valid && in_ready;

   always_comb begin
      sh_d        = sh_q;
      samples_d   = samples_q;
      cnt_d       = cnt_q;
      primed_d    = primed_q;
      busy_d      = busy_q;
      win_en_d    = 1'b0;
      win_count_d = win_count_q;

      if (busy_q && ext_done) begin
         busy_d = 1'b0;
      end

      if (accept) begin
         sh_d  = {in_sample, sh_q[WINDOW_SIZE-1:1]};
         cnt_d = cnt_q + CNT_W'(1);
         // Issue overrides a coincident done: the extractor is idle again and takes this en.
         if (boundary) begin
            samples_d   = sh_d;
            cnt_d       = '0;
            primed_d    = 1'b1;
            win_en_d    = 1'b1;
            busy_d      = 1'b1;
            win_count_d = win_count_q + COUNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q        <= '0;
         samples_q   <= '0;
         cnt_q       <= '0;
         primed_q    <= 1'b0;
         busy_q      <= 1'b0;
         win_en_q    <= 1'b0;
         win_count_q <= '0;
      end else begin
         sh_q        <= sh_d;
         samples_q   <= samples_d;
         cnt_q       <= cnt_d;
         primed_q    <= primed_d;
         busy_q      <= busy_d;
         win_en_q    <= win_en_d;
         win_count_q <= win_count_d;
      end
   end

   assign win_en    = win_en_q;
   assign samples   = samples_q;
   assign busy      = busy_q;
   assign win_count = win_count_q;

endmodule

// File: tb/tb_window_buffer.sv
// Scoreboard bench for window_buffer: a default 256/128 instance plus an 8/4 instance.
module tb_window_buffer;

   localparam int unsigned WS    = 256;
   localparam int unsigned STEP  = 128;
   localparam int unsigned SS    = 16;
   localparam int unsigned CW    = 16;
   localparam int unsigned SWS   = 8;
   localparam int unsigned SSTEP = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     rst, in_valid, ext_done, in_ready, win_en, busy;
   logic [SS-1:0]            in_sample;
   logic [WS-1:0][SS-1:0]    samples;
   logic [CW-1:0]            win_count;

   logic                     s_valid, s_done, s_ready, s_win_en, s_busy;
   logic [SS-1:0]            s_sample;
   logic [SWS-1:0][SS-1:0]   s_samples;
   logic [CW-1:0]            s_count;

   window_buffer #(.WINDOW_SIZE(WS), .WINDOW_STEP(STEP), .SAMPLE_SIZE(SS), .COUNT_W(CW)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample), .in_ready(in_ready),
      .win_en(win_en), .samples(samples), .ext_done(ext_done), .busy(busy), .win_count(win_count));

   window_buffer #(.WINDOW_SIZE(SWS), .WINDOW_STEP(SSTEP), .SAMPLE_SIZE(SS), .COUNT_W(CW)) u_small (
      .clk(clk), .rst(rst), .in_valid(s_valid), .in_sample(s_sample), .in_ready(s_ready),
      .win_en(s_win_en), .samples(s_samples), .ext_done(s_done), .busy(s_busy), .win_count(s_count));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
   endtask

   typedef struct packed {
      logic [CW-1:0]         wc;
      logic [WS-1:0][SS-1:0] win;
   } exp_t;

   // Main-instance model and scoreboard.
   int                    m_q[$];
   int                    m_cnt, m_wc;
   bit                    m_primed, m_busy;
   logic [WS-1:0][SS-1:0] m_win;
   exp_t                  exp_q[$];

   // Small-instance model.
   int                     s_q[$];
   int                     s_cnt, s_wc;
   bit                     s_primed, s_busy_m, s_pend;
   logic [SWS-1:0][SS-1:0] s_exp;

   task automatic model_reset();
      m_q.delete(); exp_q.delete();
      m_cnt = 0; m_wc = 0; m_primed = 0; m_busy = 0; m_win = '0;
      s_q.delete();
      s_cnt = 0; s_wc = 0; s_primed = 0; s_busy_m = 0; s_pend = 0; s_exp = '0;
   endtask

   task automatic cycle(input bit v, input int val, input bit done, output bit acc);
      exp_t e;
      bit   bnd;
      int   need;
      @(posedge clk); #1;
      in_valid = v; in_sample = SS'(val); ext_done = done;
      @(negedge clk);
      check("win_en", 64'(win_en), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("samples_full", 64'(samples == e.win), 64'(1));
         check("samples_first", 64'(samples[0]), 64'(e.win[0]));
         check("samples_last", 64'(samples[WS-1]), 64'(e.win[WS-1]));
         check("win_count", 64'(win_count), 64'(e.wc));
         m_win = e.win;
      end else begin
         check("samples_hold", 64'(samples == m_win), 64'(1));
      end
      check("busy", 64'(busy), 64'(m_busy));
      need = m_primed ? STEP : WS;
      bnd  = (m_cnt == need - 1);
      check("in_ready", 64'(in_ready), 64'(!(m_busy && !done && bnd)));
      acc = v && in_ready;
      if (done) m_busy = 0;
      if (acc) begin
         m_q.push_back(val);
         if (m_q.size() > WS) void'(m_q.pop_front());
         m_cnt++;
         if (bnd) begin
            for (int i = 0; i < WS; i++) e.win[i] = SS'(m_q[i]);
            m_wc++;
            e.wc = CW'(m_wc);
            exp_q.push_back(e);
            m_cnt = 0; m_primed = 1; m_busy = 1;
         end
      end
   endtask

   task automatic feed(input int val);
      bit acc;
      int tries = 0;
      do begin
         cycle(1'b1, val, 1'b0, acc);
         tries++;
      end while (!acc && tries < 20);
      if (!acc) check("feed_timeout", 64'(acc), 64'(1));
   endtask

   task automatic idle(input bit done);
      bit acc;
      cycle(1'b0, 0, done, acc);
   endtask

   task automatic s_cycle(input bit v, input int val, input bit done);
      bit bnd;
      int need;
      @(posedge clk); #1;
      s_valid = v; s_sample = SS'(val); s_done = done;
      @(negedge clk);
      check("s_win_en", 64'(s_win_en), 64'(s_pend));
      if (s_pend) begin
         check("s_samples_full", 64'(s_samples == s_exp), 64'(1));
         check("s_first", 64'(s_samples[0]), 64'(s_exp[0]));
         check("s_last", 64'(s_samples[SWS-1]), 64'(s_exp[SWS-1]));
         check("s_win_count", 64'(s_count), 64'(CW'(s_wc)));
         s_pend = 0;
      end
      check("s_busy", 64'(s_busy), 64'(s_busy_m));
      need = s_primed ? SSTEP : SWS;
      bnd  = (s_cnt == need - 1);
      check("s_ready", 64'(s_ready), 64'(!(s_busy_m && !done && bnd)));
      if (done) s_busy_m = 0;
      if (v && s_ready) begin
         s_q.push_back(val);
         if (s_q.size() > SWS) void'(s_q.pop_front());
         s_cnt++;
         if (bnd) begin
            for (int i = 0; i < SWS; i++) s_exp[i] = SS'(s_q[i]);
            s_wc++;
            s_pend = 1; s_cnt = 0; s_primed = 1; s_busy_m = 1;
         end
      end
   endtask

   task automatic do_reset(input bit v_during);
      @(posedge clk); #1;
      rst = 1'b1; in_valid = v_during; in_sample = '0; ext_done = 1'b0;
      s_valid = 1'b0; s_done = 1'b0;
      @(negedge clk);
      check("ready_in_rst", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      model_reset();
      @(negedge clk);
      check("rst_win_en", 64'(win_en), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_win_count", 64'(win_count), 64'(0));
      check("rst_samples", 64'(samples == '0), 64'(1));
      check("rst_s_win_en", 64'(s_win_en), 64'(0));
   endtask

   initial begin
      bit acc;
      rst = 1'b1; in_valid = 1'b0; in_sample = '0; ext_done = 1'b0;
      s_valid = 1'b0; s_sample = '0; s_done = 1'b0;
      model_reset();

      // First window after WINDOW_SIZE accepts.
      do_reset(1'b0);
      for (int v = 1; v <= 256; v++) feed(v);
      idle(1'b0);

      // Release the extractor, then one step of new samples.
      idle(1'b1);
      for (int v = 257; v <= 384; v++) feed(v);
      idle(1'b0);

      // Extractor still busy: boundary sample stalls until done.
      for (int v = 385; v <= 511; v++) feed(v);
      for (int k = 0; k < 10; k++) begin
         cycle(1'b1, 512, 1'b0, acc);
         check("stall_hold", 64'(acc), 64'(0));
      end
      cycle(1'b1, 512, 1'b1, acc);
      check("stall_release", 64'(acc), 64'(1));
      idle(1'b0);
      idle(1'b0);

      // Reset in the middle of FILL discards the partial window.
      do_reset(1'b0);
      for (int v = 1; v <= 100; v++) feed(v);
      do_reset(1'b1);
      for (int v = 1000; v <= 1255; v++) feed(v);
      idle(1'b0);

      // ext_done while not busy is ignored.
      idle(1'b1);
      idle(1'b0);
      idle(1'b1);
      cycle(1'b1, 1256, 1'b1, acc);
      check("done_idle_accept", 64'(acc), 64'(1));
      idle(1'b0);

      // Small build: toggling valid, idle cycles must not count.
      do_reset(1'b0);
      for (int k = 0; k < 16; k++) s_cycle((k % 2) == 0, 10 + k / 2, 1'b0);
      s_cycle(1'b0, 0, 1'b1);
      for (int k = 0; k < 8; k++) s_cycle((k % 2) == 0, 18 + k / 2, 1'b0);
      s_cycle(1'b0, 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
